// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline/arbiter port: width defaults, stall FSM
// encoding and a constant-evaluable clog2 helper.
package pipeline_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_STAGES    = 2;
    localparam int DEF_BUF_DEPTH = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipeline_arb_fifo.sv
// Circular buffer feeding the arbiter: head is visible combinationally,
// flush empties it in one cycle, occupancy runs 0..DEPTH inclusive.
module pipeline_arb_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_head,
    output logic [clog2(DEPTH):0]   o_occ,
    output logic [clog2(DEPTH):0]   o_occ_next
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign w_pop_ok   = i_pop && (r_occ != '0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_push_ok  = i_push && ((r_occ != OCC_W'(DEPTH)) || w_pop_ok);
    assign o_occ_next = r_occ + OCC_W'(w_push_ok) - OCC_W'(w_pop_ok);
    assign o_occ      = r_occ;
    assign o_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_occ <= o_occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pipeline_arb_port.sv
// Valid-tracked pipeline into a buffered req/grant port, with a hysteretic
// global stall, flush, starvation flag and registered resource response.
module pipeline_arb_port
    import pipeline_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STAGES     = DEF_STAGES,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int HI_WM      = 3,
    parameter int LO_WM      = 1,
    parameter int STARVE_CYC = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    input  logic                        arbiter_grant,
    output logic                        arbiter_req,
    output logic [DATA_W-1:0]           resource_input,
    input  logic                        resource_valid,
    input  logic [DATA_W-1:0]           resource_output,
    output logic [DATA_W-1:0]           outputs,
    output logic                        out_valid,
    output logic                        stall_signal,
    output logic                        starve,
    output logic [clog2(BUF_DEPTH):0]   occupancy
);

    localparam int OCC_W = clog2(BUF_DEPTH) + 1;
    localparam int CNT_W = clog2(STARVE_CYC) + 1;

    stall_state_t      r_state;
    stall_state_t      w_state_next;
    logic [OCC_W-1:0]  w_occ_next;
    logic              w_push;
    logic              w_pop;
    logic              w_last_valid;
    logic [DATA_W-1:0] w_last_data;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_starve;
    logic [DATA_W-1:0] r_outputs;
    logic              r_out_valid;

    assign stall_signal = (r_state == ST_STALL);
    assign in_ready     = ~stall_signal;
    assign arbiter_req  = (occupancy != '0);
    assign starve       = r_starve;
    assign outputs      = r_outputs;
    assign out_valid    = r_out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [DATA_W-1:0] r_data;
            logic              r_valid;
            logic [DATA_W-1:0] w_src_data;
            logic              w_src_valid;

            if (gi == 0) begin : g_first
                assign w_src_data  = in_data;
                assign w_src_valid = in_valid;
            end else begin : g_next
                assign w_src_data  = g_stage[gi-1].r_data;
                assign w_src_valid = g_stage[gi-1].r_valid;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)             r_valid <= 1'b0;
                else if (flush)         r_valid <= 1'b0;
                else if (!stall_signal) r_valid <= w_src_valid;
            end

            always_ff @(posedge clk) begin
                if (!stall_signal) r_data <= w_src_data;
            end
        end
    endgenerate

    assign w_last_valid = g_stage[STAGES-1].r_valid;
    assign w_last_data  = g_stage[STAGES-1].r_data;

    assign w_push = w_last_valid & ~stall_signal & ~flush;
    assign w_pop  = arbiter_grant & arbiter_req & ~flush;

    pipeline_arb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (flush),
        .i_data     (w_last_data),
        .o_head     (resource_input),
        .o_occ      (occupancy),
        .o_occ_next (w_occ_next)
    );

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   if (w_occ_next >= OCC_W'(HI_WM)) w_state_next = ST_STALL;
                ST_STALL: if (w_occ_next <= OCC_W'(LO_WM)) w_state_next = ST_RUN;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    // The flag only ever sets; reset is the sole way to clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            if (arbiter_req && !arbiter_grant && (r_starve_cnt == CNT_W'(STARVE_CYC - 1)))
                r_starve <= 1'b1;
            if (flush || !arbiter_req || arbiter_grant)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != '1)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outputs   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= resource_valid;
            if (resource_valid) r_outputs <= resource_output;
        end
    end

endmodule

// File: tb/tb_pipeline_arb_port.sv
// Directed bench for pipeline_arb_port: a cycle model of occupancy, stall and
// starvation plus a scoreboard of accepted beats checked at every pop.
module tb_pipeline_arb_port;

    localparam int DW = 32;
    localparam int ST = 2;
    localparam int BD = 4;
    localparam int HI = 3;
    localparam int LO = 1;
    localparam int SC = 16;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          arbiter_grant;
    logic          arbiter_req;
    logic [DW-1:0] resource_input;
    logic          resource_valid;
    logic [DW-1:0] resource_output;
    logic [DW-1:0] outputs;
    logic          out_valid;
    logic          stall_signal;
    logic          starve;
    logic [2:0]    occupancy;

    pipeline_arb_port #(
        .DATA_W(DW), .STAGES(ST), .BUF_DEPTH(BD),
        .HI_WM(HI), .LO_WM(LO), .STARVE_CYC(SC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .arbiter_grant   (arbiter_grant),
        .arbiter_req     (arbiter_req),
        .resource_input  (resource_input),
        .resource_valid  (resource_valid),
        .resource_output (resource_output),
        .outputs         (outputs),
        .out_valid       (out_valid),
        .stall_signal    (stall_signal),
        .starve          (starve),
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_vec;
    int            n_err;
    logic [DW-1:0] exp_q[$];

    bit            m_sv[ST];
    int            m_occ;
    bit            m_stall;
    int            m_cnt;
    bit            m_starve;
    bit            m_ov;
    logic [DW-1:0] m_out;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ST; i++) m_sv[i] = 1'b0;
        m_occ = 0; m_stall = 1'b0; m_cnt = 0; m_starve = 1'b0;
        m_ov = 1'b0; m_out = '0;
        exp_q.delete();
    endtask

    task automatic chk_state(input string pfx);
        chk({pfx, "_occ"},       occupancy,      m_occ);
        chk({pfx, "_stall"},     stall_signal,   m_stall);
        chk({pfx, "_in_ready"},  in_ready,       !m_stall);
        chk({pfx, "_req"},       arbiter_req,    m_occ != 0);
        chk({pfx, "_out_valid"}, out_valid,      m_ov);
        chk({pfx, "_outputs"},   outputs,        m_out);
        chk({pfx, "_starve"},    starve,         m_starve);
    endtask

    // One clock: predict the edge from the current inputs, cross it, compare.
    task automatic tick();
        bit acc, push, pop, req;
        int occn;
        #1;
        req  = (m_occ != 0);
        acc  = in_valid && !m_stall && !flush;
        push = m_sv[ST-1] && !m_stall && !flush;
        pop  = arbiter_grant && req && !flush;
        if (pop && exp_q.size() > 0) chk("head", resource_input, exp_q.pop_front());
        if (flush)    exp_q.delete();
        else if (acc) exp_q.push_back(in_data);
        occn = m_occ + int'(push) - int'(pop);
        if (req && !arbiter_grant && m_cnt == SC - 1) m_starve = 1'b1;
        if (flush || !req || arbiter_grant) m_cnt = 0;
        else if (m_cnt < 31) m_cnt++;
        if (flush) begin
            for (int i = 0; i < ST; i++) m_sv[i] = 1'b0;
            m_occ = 0; m_stall = 1'b0;
        end else begin
            if (!m_stall) begin
                for (int i = ST - 1; i > 0; i--) m_sv[i] = m_sv[i-1];
                m_sv[0] = in_valid;
            end
            if (!m_stall && occn >= HI)     m_stall = 1'b1;
            else if (m_stall && occn <= LO) m_stall = 1'b0;
            m_occ = occn;
        end
        m_ov = resource_valid;
        if (resource_valid) m_out = resource_output;
        @(posedge clk);
        #1;
        chk_state("cyc");
    endtask

    int  first_req;
    bit  saw_stall;
    int  max_occ;

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
        arbiter_grant = 1'b0; resource_valid = 1'b0; resource_output = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_state("rst");
        reset = 1'b1;

        // 1: reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h10 + i;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        chk_state("rst_async");
        @(posedge clk);
        #1;
        chk_state("rst_mid");
        reset = 1'b1;
        tick();

        // 2: flow with grant held; grant on an empty buffer must be ignored
        arbiter_grant = 1'b1;
        first_req = -1; saw_stall = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            in_valid = (c <= 5);
            in_data  = 32'hA0 + c - 1;
            tick();
            if (arbiter_req && first_req < 0) first_req = c;
            if (stall_signal) saw_stall = 1'b1;
        end
        in_valid = 1'b0;
        // One edge per stage register, then the buffer write.
        chk("flow_first_req_cycle", first_req, ST + 1);
        chk("flow_no_stall", saw_stall, 1'b0);

        // 3: backpressure then recovery
        arbiter_grant = 1'b0;
        saw_stall = 1'b0; max_occ = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) arbiter_grant = 1'b1;
            in_valid = (c < 18);
            in_data  = 32'hB0 + c;
            tick();
            if (stall_signal) saw_stall = 1'b1;
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        in_valid = 1'b0;
        chk("bp_stall_seen", saw_stall, 1'b1);
        chk("bp_occ_le_depth", max_occ <= BD, 1'b1);
        chk("bp_drained_occ", occupancy, 3'd0);

        // 4: push and pop in the same cycle at occupancy 2
        arbiter_grant = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 32'hC0 + c;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pp_pre_occ", occupancy, 3'd2);
        arbiter_grant = 1'b1;
        tick();
        arbiter_grant = 1'b0;
        chk("pp_occ", occupancy, 3'd2);
        chk("pp_head", resource_input, 32'hC1);

        // 5: flush while stalled, with a same-cycle grant and response
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 32'hD0 + c;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8 && occupancy != 3'd3; k++) tick();
        chk("fl_pre_occ", occupancy, 3'd3);
        chk("fl_pre_stall", stall_signal, 1'b1);
        flush = 1'b1; arbiter_grant = 1'b1;
        resource_valid = 1'b1; resource_output = 32'h55;
        tick();
        flush = 1'b0; arbiter_grant = 1'b0; resource_valid = 1'b0;
        chk("fl_occ", occupancy, 3'd0);
        chk("fl_stall", stall_signal, 1'b0);
        chk("fl_outputs", outputs, 32'h55);
        chk("fl_out_valid", out_valid, 1'b1);
        repeat (4) tick();
        chk("fl_valids_cleared", occupancy, 3'd0);
        chk("fl_out_valid_pulse", out_valid, 1'b0);

        // 6: starvation
        in_valid = 1'b1; in_data = 32'hE0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !arbiter_req; k++) tick();
        chk("sv_req", arbiter_req, 1'b1);
        for (int k = 1; k <= SC; k++) begin
            tick();
            if (k == SC - 1) chk("sv_not_yet", starve, 1'b0);
            if (k == SC)     chk("sv_set", starve, 1'b1);
        end
        arbiter_grant = 1'b1;
        tick();
        arbiter_grant = 1'b0;
        tick();
        chk("sv_sticky", starve, 1'b1);
        chk("sv_drained", occupancy, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
